// File: rtl/hazard_pkg.sv
// Shared types for the decode/execute hazard controller.
// Slot bundle, forward-select encoding and the x0 index.
package hazard_pkg;

    localparam int SLOT_RD_W = 5;

    localparam logic [SLOT_RD_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 rd_write;
        logic                 is_load;
    } slot_t;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Compares one decode source index against the EX and MEM slots.
// Returns the forward select (EX wins over MEM) and a load-use hit.
module hazard_fwd_cmp
    import hazard_pkg::*;
(
    input  logic [SLOT_RD_W-1:0] rs_i,
    input  logic                 rs_read_i,
    input  slot_t                ex_i,
    input  slot_t                mem_i,
    output fwd_sel_t             sel_o,
    output logic                 load_use_o
);

    logic rs_live;
    logic ex_hit;
    logic mem_hit;

    assign rs_live = rs_read_i && (rs_i != REG_X0);

    assign ex_hit = rs_live && ex_i.valid && ex_i.rd_write
                    && (ex_i.rd == rs_i);

    assign mem_hit = rs_live && mem_i.valid && mem_i.rd_write
                     && (mem_i.rd == rs_i);

    assign load_use_o = rs_live && ex_i.valid && ex_i.is_load
                        && (ex_i.rd == rs_i);

    // Youngest producer wins; both may match at once.
    always_comb begin
        sel_o = FWD_RF;
        priority case (1'b1)
            ex_hit:  sel_o = FWD_EX;
            mem_hit: sel_o = FWD_MEM;
            default: sel_o = FWD_RF;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding/flush controller beside decode and execute.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  req,
    input  logic                  reset,
    input  logic                  dec_valid_in,
    input  logic [REG_ADDR_W-1:0] rs1_unreg_in,
    input  logic                  rs1_read_unreg_in,
    input  logic [REG_ADDR_W-1:0] rs2_unreg_in,
    input  logic                  rs2_read_unreg_in,
    input  logic [REG_ADDR_W-1:0] dec_rd_in,
    input  logic                  dec_rd_write_in,
    input  logic                  dec_is_load_in,
    input  logic                  branch_taken_in,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stall_cnt_out,
    output logic [31:0]           flush_cnt_out,
`endif
    output logic                  stall_out,
    output logic                  flush_out,
    output logic                  valid_ex_out,
    output logic [1:0]            fwd_rs1_sel_out,
    output logic [1:0]            fwd_rs2_sel_out
);

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    // Slots are sized by the package; mismatched widths are a build error.
    if (REG_ADDR_W != SLOT_RD_W) begin : g_width_chk
        $error("REG_ADDR_W must equal hazard_pkg::SLOT_RD_W");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_flush_chk
        $error("FLUSH_CYCLES must be in 1..7");
    end

    slot_t      ex_q;
    slot_t      ex_d;
    slot_t      mem_q;
    logic [2:0] flush_cnt_q;
    logic [2:0] flush_cnt_d;

    fwd_sel_t   rs1_sel;
    fwd_sel_t   rs2_sel;
    logic       rs1_lu;
    logic       rs2_lu;

    hazard_fwd_cmp u_cmp_rs1 (
        .rs_i       (rs1_unreg_in),
        .rs_read_i  (rs1_read_unreg_in),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (rs1_sel),
        .load_use_o (rs1_lu)
    );

    hazard_fwd_cmp u_cmp_rs2 (
        .rs_i       (rs2_unreg_in),
        .rs_read_i  (rs2_read_unreg_in),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .sel_o      (rs2_sel),
        .load_use_o (rs2_lu)
    );

    assign fwd_rs1_sel_out = rs1_sel;
    assign fwd_rs2_sel_out = rs2_sel;
    assign valid_ex_out    = ex_q.valid;

    // Flush has priority: a killed instruction never needs a hold.
    always_comb begin
        flush_out = branch_taken_in || (flush_cnt_q != 3'd0);
        stall_out = dec_valid_in && (rs1_lu || rs2_lu) && !flush_out;
    end

    // Next EX slot and next flush count.
    always_comb begin
        ex_d = '0;
        if (dec_valid_in && !stall_out && !flush_out) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = dec_rd_in;
            ex_d.rd_write = dec_rd_write_in;
            ex_d.is_load  = dec_is_load_in;
        end
        flush_cnt_d = flush_cnt_q;
        if (branch_taken_in) begin
            flush_cnt_d = FLUSH_LD;
        end else if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end
    end

    // Two-deep slot shift register plus flush counter.
    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            flush_cnt_q <= 3'd0;
        end else begin
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_stat_q;

    // Saturating event counters.
    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            stall_cnt_q      <= '0;
            flush_cnt_stat_q <= '0;
        end else begin
            if (stall_out && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_out && (flush_cnt_stat_q != 32'hFFFF_FFFF)) begin
                flush_cnt_stat_q <= flush_cnt_stat_q + 32'd1;
            end
        end
    end

    assign stall_cnt_out = stall_cnt_q;
    assign flush_cnt_out = flush_cnt_stat_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: history model plus directed program.
// Build with HAZARD_STATS_EN to also check the event counters.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;

    logic       req = 1'b0;
    logic       reset = 1'b0;
    logic       dec_v = 1'b0;
    logic [4:0] r1 = '0;
    logic       r1rd = 1'b0;
    logic [4:0] r2 = '0;
    logic       r2rd = 1'b0;
    logic [4:0] drd = '0;
    logic       dw = 1'b0;
    logic       dld = 1'b0;
    logic       br = 1'b0;

    logic       stall;
    logic       flush;
    logic       vex;
    logic [1:0] s1;
    logic [1:0] s2;
`ifdef HAZARD_STATS_EN
    logic [31:0] scnt;
    logic [31:0] fcnt;
`endif

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (5),
        .FLUSH_CYCLES (FC)
    ) dut (
        .req               (req),
        .reset             (reset),
        .dec_valid_in      (dec_v),
        .rs1_unreg_in      (r1),
        .rs1_read_unreg_in (r1rd),
        .rs2_unreg_in      (r2),
        .rs2_read_unreg_in (r2rd),
        .dec_rd_in         (drd),
        .dec_rd_write_in   (dw),
        .dec_is_load_in    (dld),
        .branch_taken_in   (br),
`ifdef HAZARD_STATS_EN
        .stall_cnt_out     (scnt),
        .flush_cnt_out     (fcnt),
`endif
        .stall_out         (stall),
        .flush_out         (flush),
        .valid_ex_out      (vex),
        .fwd_rs1_sel_out   (s1),
        .fwd_rs2_sel_out   (s2)
    );

    always #5 req = ~req;

    int nrun = 0;
    int nfail = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: list of the last two issued instructions, newest first,
    // and the number of edges since the last taken branch.
    typedef struct {
        bit v;
        int rd;
        bit w;
        bit ld;
    } ent_t;

    ent_t hist[2];
    int   since = FC + 1;
    int   m_stalls = 0;
    int   m_flushes = 0;

    function automatic int m_fwd(int idx, bit en);
        for (int a = 0; a < 2; a++) begin
            if (en && idx != 0 && hist[a].v && hist[a].w && hist[a].rd == idx)
                return a + 1;
        end
        return 0;
    endfunction

    function automatic bit m_flush();
        return br || (since <= FC);
    endfunction

    function automatic bit m_stall();
        bit hit;
        hit = dec_v && hist[0].v && hist[0].ld && hist[0].rd != 0
              && ((r1rd && hist[0].rd == int'(r1))
                  || (r2rd && hist[0].rd == int'(r2)));
        return hit && !m_flush();
    endfunction

    always @(posedge req or negedge reset) begin
        ent_t n;
        if (!reset) begin
            hist[0] = '{0, 0, 0, 0};
            hist[1] = '{0, 0, 0, 0};
            since = FC + 1;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            n = '{0, 0, 0, 0};
            if (dec_v && !m_stall() && !m_flush())
                n = '{1, int'(drd), dw, dld};
            if (m_stall()) m_stalls++;
            if (m_flush()) m_flushes++;
            hist[1] = hist[0];
            hist[0] = n;
            if (br) since = 1;
            else if (since <= FC) since++;
        end
    end

    // Every cycle: DUT against model.
    always @(negedge req) begin
        bit live;
        live = (reset === 1'b1);
        check("m_stall", 32'(stall), live ? 32'(m_stall()) : 0);
        check("m_flush", 32'(flush), live ? 32'(m_flush()) : 0);
        check("m_vex", 32'(vex), live ? 32'(hist[0].v) : 0);
        check("m_sel1", 32'(s1), live ? 32'(m_fwd(int'(r1), r1rd)) : 0);
        check("m_sel2", 32'(s2), live ? 32'(m_fwd(int'(r2), r2rd)) : 0);
`ifdef HAZARD_STATS_EN
        check("m_scnt", scnt, 32'(m_stalls));
        check("m_fcnt", fcnt, 32'(m_flushes));
`endif
    end

    // Drive one decode cycle, then wait to its sampling point.
    task automatic step(input bit v, input int a, input bit ar,
                        input int b, input bit bre, input int d,
                        input bit w, input bit l, input bit bt);
        @(posedge req);
        #1;
        dec_v = v;
        r1 = 5'(a);
        r1rd = ar;
        r2 = 5'(b);
        r2rd = bre;
        drd = 5'(d);
        dw = w;
        dld = l;
        br = bt;
        @(negedge req);
    endtask

    initial begin
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_vex", 32'(vex), 0);
        #11 reset = 1'b1;

        // addi x1,x0,1 ; add x2,x1,x1
        step(1, 0, 1, 0, 0, 1, 1, 0, 0);
        check("t1_sel1", 32'(s1), 0);
        step(1, 1, 1, 1, 1, 2, 1, 0, 0);
        check("t2_sel1", 32'(s1), 1);
        check("t2_sel2", 32'(s2), 1);
        check("t2_stall", 32'(stall), 0);

        // x3 write, unrelated, read x3 -> MEM forward
        step(1, 0, 1, 0, 0, 3, 1, 0, 0);
        step(1, 0, 1, 0, 0, 4, 1, 0, 0);
        step(1, 3, 1, 0, 1, 7, 1, 0, 0);
        check("t5_sel1", 32'(s1), 2);
        check("t5_sel2", 32'(s2), 0);

        // lw x5 ; add x6,x5,x0 -> one stall, bubble, MEM forward
        step(1, 0, 1, 0, 0, 5, 1, 1, 0);
        step(1, 5, 1, 0, 1, 6, 1, 0, 0);
        check("t7_stall", 32'(stall), 1);
        check("t7_sel1", 32'(s1), 1);
        step(1, 5, 1, 0, 1, 6, 1, 0, 0);
        check("t8_stall", 32'(stall), 0);
        check("t8_vex", 32'(vex), 0);
        check("t8_sel1", 32'(s1), 2);

        // lw x0 ; add x8,x0,x0 -> nothing forwarded, no stall
        step(1, 0, 1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 1, 0, 1, 8, 1, 0, 0);
        check("t10_sel1", 32'(s1), 0);
        check("t10_sel2", 32'(s2), 0);
        check("t10_stall", 32'(stall), 0);

        // lw x9 ; add x10,x9,x9 with a taken branch
        step(1, 0, 1, 0, 0, 9, 1, 1, 0);
        step(1, 9, 1, 9, 1, 10, 1, 0, 1);
        check("t12_flush", 32'(flush), 1);
        check("t12_stall", 32'(stall), 0);
        step(1, 9, 1, 9, 1, 10, 1, 0, 0);
        check("t13_flush", 32'(flush), 1);
        check("t13_vex", 32'(vex), 0);
        step(1, 9, 1, 9, 1, 10, 1, 0, 0);
        check("t14_flush", 32'(flush), 1);
        step(1, 0, 1, 0, 0, 12, 1, 0, 0);
        check("t15_flush", 32'(flush), 0);

        // addi x11 ; branch ; read x11 while flushing, then reset
        step(1, 0, 1, 0, 0, 11, 1, 0, 0);
        step(1, 0, 1, 0, 0, 13, 1, 0, 1);
        check("t17_vex", 32'(vex), 1);
        step(1, 11, 1, 0, 0, 14, 1, 0, 0);
        check("t18_flush", 32'(flush), 1);
        check("t18_sel1", 32'(s1), 2);
        #2 reset = 1'b0;
        #1;
        check("r_flush", 32'(flush), 0);
        check("r_sel1", 32'(s1), 0);
        check("r_vex", 32'(vex), 0);
        check("r_stall", 32'(stall), 0);
`ifdef HAZARD_STATS_EN
        check("r_scnt", scnt, 0);
        check("r_fcnt", fcnt, 0);
`endif
        @(posedge req);
        @(negedge req);
        #3 reset = 1'b1;

        step(1, 11, 1, 11, 1, 15, 1, 0, 0);
        check("p_sel1", 32'(s1), 0);
        check("p_sel2", 32'(s2), 0);
        check("p_flush", 32'(flush), 0);
        step(1, 15, 1, 0, 0, 16, 1, 0, 0);
        check("p2_sel1", 32'(s1), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the decode/execute pipeline of the RV32I core.
- Tracks in-flight destination registers in two internal slots (EX, MEM) and compares them against decode's unregistered rs1/rs2 read requests.
- Drives forwarding selects into execute, a load-use stall into decode, and a bubble/flush on taken branches.
- Sits beside decode and execute. Its valid_ex_out replaces the direct ~valid_out wiring into execute's stall_in.

Parameters:
- REG_ADDR_W, 5, register index width.
- FLUSH_CYCLES, 2, cycles flush_out stays high after a taken branch (1..7).

Ports:
- req  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- dec_valid_in  input  1  decode holds a valid instruction.
- rs1_unreg_in  input  REG_ADDR_W  decode rs1 index (unregistered).
- rs1_read_unreg_in  input  1  rs1 is actually read.
- rs2_unreg_in  input  REG_ADDR_W  decode rs2 index.
- rs2_read_unreg_in  input  1  rs2 is actually read.
- dec_rd_in  input  REG_ADDR_W  decode destination index.
- dec_rd_write_in  input  1  decode instruction writes rd.
- dec_is_load_in  input  1  decode instruction is a load.
- branch_taken_in  input  1  execute resolved a taken branch/jump this cycle.
- stall_out  output  1  hold decode/fetch; insert bubble into EX.
- flush_out  output  1  kill instruction in decode.
- valid_ex_out  output  1  EX slot holds a live instruction; execute stall_in = ~valid_ex_out.
- fwd_rs1_sel_out  output  2  00 regfile, 01 EX result, 10 MEM result, 11 unused.
- fwd_rs2_sel_out  output  2  same encoding for rs2.

Behaviour:
- Slot contents: each slot holds {valid, rd, rd_write, is_load}. On reset (async, reset=0): both slots cleared, flush counter = 0, all outputs 0.
- Forward selects (combinational from the registered slots):
  - rsN_sel = 01 if rsN_read && EX.valid && EX.rd_write && EX.rd==rsN && rsN!=0.
  - Otherwise 10 if the same condition holds for the MEM slot.
  - Otherwise 00.
  - EX has priority over MEM. Index 0 is never forwarded.
- Load-use stall (combinational): stall_out=1 if dec_valid_in && EX.valid && EX.is_load && EX.rd!=0 && (rs1 match with rs1_read || rs2 match with rs2_read). Asserted for exactly one cycle per hazard; the next cycle sees the load in MEM, where the 10 forward applies.
- Flush:
  - branch_taken_in=1 loads the counter with FLUSH_CYCLES.
  - flush_out = (counter!=0) || branch_taken_in.
  - The counter decrements each cycle to 0.
  - A branch_taken_in while the counter is nonzero reloads it.
- Slot update on each rising req edge:
  - MEM <= EX.
  - EX <= bubble (valid=0) if stall_out || flush_out || !dec_valid_in; otherwise EX <= {1, dec_rd_in, dec_rd_write_in, dec_is_load_in}.
- Simultaneous events:
  - Flush overrides stall: stall_out forced 0 while flush_out=1, because the killed instruction needs no hold.
  - Forward selects are still driven during flush, but are don't-care.
- valid_ex_out = EX.valid.
- Zero latency: stall, flush and forward outputs are valid in the same cycle as the decode inputs.
- No FSM beyond the flush counter (states IDLE when counter=0, FLUSHING when counter>0) and the 2-deep slot shift register.
- Reset asserted mid-operation: slots and counter clear immediately, without waiting for a clock edge.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined:
  - Adds outputs stall_cnt_out[31:0] and flush_cnt_out[31:0].
  - Each counter increments on every req edge where stall_out (respectively flush_out) is high.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - typedef fwd_sel_t (2-bit enum FWD_RF, FWD_EX, FWD_MEM).
  - struct slot_t {valid, rd, rd_write, is_load}.
  - constant REG_X0 = 0.
- One sub-module, hazard_fwd_cmp: a combinational comparator for a single rs index against both slots, returning fwd_sel_t and a load-use match. It is instantiated twice, for rs1 and rs2.

Test Plan:
- addi x1,x0,1 then add x2,x1,x1 back-to-back -> cycle 2: fwd_rs1_sel=01, fwd_rs2_sel=01, stall_out=0.
- Write x3, one unrelated instruction, then read x3 -> third instruction sees fwd_rs1_sel=10.
- Load to x5 followed by add x6,x5,x0 -> stall_out=1 for one cycle, EX bubble (valid_ex_out=0 next cycle), then fwd_rs1_sel=10.
- Write to x0, then read x0 -> both selects 00, no stall, even when the x0 writer is a load.
- branch_taken_in pulse with FLUSH_CYCLES=2 -> flush_out high for 3 cycles (pulse cycle + 2), EX bubbles, and a concurrent load-use stall is suppressed.
- reset driven low mid-flush with EX/MEM occupied -> all outputs 0 immediately; after release the first instruction sees selects 00. With HAZARD_STATS_EN, the counters read 0.
